// File: rtl/reg_file_fwd.sv
// CPU register file: two registered read ports, one write port with same-cycle
// write->read forwarding, a read-only PC slot, and a sequenced array clear.
module reg_file_fwd #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned PC_IDX    = 15,
    parameter int unsigned PC_OFFSET = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic [ADDR_W-1:0] a1,
    input  logic [ADDR_W-1:0] a2,
    input  logic [ADDR_W-1:0] a3,
    input  logic [DATA_W-1:0] wd3,
    input  logic              we3,
    input  logic [DATA_W-1:0] pc_in,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              busy,
    output logic              pc_wr_ignored
);

    localparam int unsigned NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);
    // Clear walks every index except the PC slot.
    localparam logic [ADDR_W-1:0] FIRST_IDX = (PC_IDX == 0) ? ADDR_W'(1) : ADDR_W'(0);
    localparam logic [ADDR_W-1:0] LAST_IDX  = (PC_IDX == NREGS - 1) ? ADDR_W'(NREGS - 2)
                                                                     : ADDR_W'(NREGS - 1);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] clr_cnt_nxt;
    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] pc_val_c;
    logic [DATA_W-1:0] rd1_nxt;
    logic [DATA_W-1:0] rd2_nxt;
    logic              wr_en_c;
    logic              pc_wr_c;

    assign pc_val_c = pc_in + DATA_W'(PC_OFFSET);

    // Next-state, clear-counter stepping, read muxing and write qualification.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        rd1_nxt     = '0;
        rd2_nxt     = '0;
        wr_en_c     = 1'b0;
        pc_wr_c     = 1'b0;
        case (state)
            CLEAR: begin
                if (clr_cnt == LAST_IDX) begin
                    state_nxt = READY;
                end else if (clr_cnt + ADDR_W'(1) == PC_A) begin
                    clr_cnt_nxt = clr_cnt + ADDR_W'(2);
                end else begin
                    clr_cnt_nxt = clr_cnt + ADDR_W'(1);
                end
            end
            READY: begin
                if (a1 == PC_A)                rd1_nxt = pc_val_c;
                else if (we3 && (a3 == a1))    rd1_nxt = wd3;
                else                           rd1_nxt = regs[a1];

                if (a2 == PC_A)                rd2_nxt = pc_val_c;
                else if (we3 && (a3 == a2))    rd2_nxt = wd3;
                else                           rd2_nxt = regs[a2];

                // A clear request takes priority over any same-cycle write.
                if (clr) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = FIRST_IDX;
                end else if (we3) begin
                    if (a3 == PC_A) pc_wr_c = 1'b1;
                    else            wr_en_c = 1'b1;
                end
            end
            default: begin
                state_nxt   = CLEAR;
                clr_cnt_nxt = FIRST_IDX;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= CLEAR;
            clr_cnt       <= FIRST_IDX;
            rd1           <= '0;
            rd2           <= '0;
            busy          <= 1'b1;
            pc_wr_ignored <= 1'b0;
        end else begin
            state         <= state_nxt;
            clr_cnt       <= clr_cnt_nxt;
            rd1           <= rd1_nxt;
            rd2           <= rd2_nxt;
            busy          <= (state_nxt == CLEAR);
            pc_wr_ignored <= pc_wr_c;
        end
    end

    // Storage array: no reset; contents are zeroed by the clear sequence.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) regs[clr_cnt] <= '0;
            else if (wr_en_c)   regs[a3]      <= wd3;
        end
    end

endmodule
